// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: one instance per CPU port
// (instruction fetch or load/store). The requester drives the master
// modport; the arbiter uses the slave modport.
interface ram_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter and sequencer for a single-port synchronous RAM
// with a one-cycle registered read. Port A is instruction fetch, port B is
// load/store. One access is granted at a time; reads return data to the
// owner two cycles after the grant with a one-cycle rvalid pulse.
//
// Build option: define RAM_ARB_FIXED_PRIO_EN to make port A win every tie;
// by default ties alternate round-robin using the last granted port.
module ram_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   ram_arbiter_if.slave          a,
   ram_arbiter_if.slave          b,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  busy
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RD_WAIT = 2'd1;
   localparam logic [1:0] ST_RD_RESP = 2'd2;

   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

   logic [1:0]            state_q,      state_d;
   logic                  owner_q,      owner_d;
   logic                  last_owner_q, last_owner_d;
   logic [ADDR_WIDTH-1:0] addr_hold_q,  addr_hold_d;
   logic [DATA_WIDTH-1:0] wdata_hold_q, wdata_hold_d;
   logic [DATA_WIDTH-1:0] a_rdata_q,    a_rdata_d;
   logic [DATA_WIDTH-1:0] b_rdata_q,    b_rdata_d;

   logic                  can_grant;
   logic                  tie_pick_a;
   logic                  a_win;
   logic                  b_win;
   logic                  grant;
   logic                  win_we;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_wdata;

`ifdef RAM_ARB_FIXED_PRIO_EN
   assign tie_pick_a = 1'b1;
`else
   assign tie_pick_a = (last_owner_q == OWNER_B);
`endif

   // Combinational grant decision and winner's request mux.
   always_comb begin
      // Grants are suppressed while reset is held so no gnt or ram_we
      // can leak out of an asserted reset.
      can_grant = rst && ((state_q == ST_IDLE) || (state_q == ST_RD_RESP));
      a_win     = can_grant && a.req && (!b.req || tie_pick_a);
      b_win     = can_grant && b.req && (!a.req || !tie_pick_a);
      grant     = a_win || b_win;
      win_we    = b_win ? b.we    : a.we;
      win_addr  = b_win ? b.addr  : a.addr;
      win_wdata = b_win ? b.wdata : a.wdata;
   end

   // Next-state logic: sequencing, ownership and read-data capture.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_d      = ST_IDLE;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      addr_hold_d  = addr_hold_q;
      wdata_hold_d = wdata_hold_q;
      a_rdata_d    = a_rdata_q;
      b_rdata_d    = b_rdata_q;

      if (grant) begin
         state_d      = win_we ? ST_IDLE : ST_RD_WAIT;
         owner_d      = b_win ? OWNER_B : OWNER_A;
         last_owner_d = b_win ? OWNER_B : OWNER_A;
         addr_hold_d  = win_addr;
         wdata_hold_d = win_wdata;
      end else if (state_q == ST_RD_WAIT) begin
         state_d = ST_RD_RESP;
      end

      // The RAM presents read data in the cycle after the read grant.
      if (state_q == ST_RD_WAIT) begin
         if (owner_q == OWNER_B) begin
            b_rdata_d = ram_rdata;
         end else begin
            a_rdata_d = ram_rdata;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWNER_A;
         last_owner_q <= OWNER_B;
         addr_hold_q  <= '0;
         wdata_hold_q <= '0;
         a_rdata_q    <= '0;
         b_rdata_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         addr_hold_q  <= addr_hold_d;
         wdata_hold_q <= wdata_hold_d;
         a_rdata_q    <= a_rdata_d;
         b_rdata_q    <= b_rdata_d;
      end
   end

   // Requester responses: gnt is combinational, rvalid follows RD_RESP.
   assign a.gnt    = a_win;
   assign b.gnt    = b_win;
   assign a.rvalid = (state_q == ST_RD_RESP) && (owner_q == OWNER_A);
   assign b.rvalid = (state_q == ST_RD_RESP) && (owner_q == OWNER_B);
   assign a.rdata  = a_rdata_q;
   assign b.rdata  = b_rdata_q;

   // RAM side: driven from the winner in the grant cycle, otherwise the
   // address and data hold their last values and write enable is low.
   assign ram_we    = grant && win_we;
   assign ram_addr  = grant ? win_addr  : addr_hold_q;
   assign ram_wdata = grant ? win_wdata : wdata_hold_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a directed cycle table, a reset-
// during-read sequence, and a randomized run against a cycle-level model
// built from the grant/latency rules and a 256-entry memory scoreboard.
module tb_ram_arbiter;

   localparam int AW = 8;
   localparam int DW = 8;
`ifdef RAM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   localparam bit Y = 1'b1;
   localparam bit N = 1'b0;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          busy;

   always #5 clk = ~clk;

   ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) pa ();
   ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) pb ();

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (pa),
      .b         (pb),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .busy      (busy)
   );

   // Single-port synchronous RAM with a one-cycle registered read.
   logic [DW-1:0] mem [256];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit ar, input bit aw, input logic [7:0] aa, input logic [7:0] awd,
                        input bit br, input bit bw, input logic [7:0] ba, input logic [7:0] bwd);
      pa.req = ar; pa.we = aw; pa.addr = aa; pa.wdata = awd;
      pb.req = br; pb.we = bw; pb.addr = ba; pb.wdata = bwd;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " a_gnt"},     32'(pa.gnt),    0);
      check({tag, " b_gnt"},     32'(pb.gnt),    0);
      check({tag, " a_rvalid"},  32'(pa.rvalid), 0);
      check({tag, " b_rvalid"},  32'(pb.rvalid), 0);
      check({tag, " ram_we"},    32'(ram_we),    0);
      check({tag, " ram_addr"},  32'(ram_addr),  0);
      check({tag, " ram_wdata"}, 32'(ram_wdata), 0);
      check({tag, " a_rdata"},   32'(pa.rdata),  0);
      check({tag, " b_rdata"},   32'(pb.rdata),  0);
      check({tag, " busy"},      32'(busy),      0);
   endtask

   // Called at a falling edge: pulses reset well clear of the next rising edge.
   task automatic do_reset(input string tag);
      drive(N, N, 8'h00, 8'h00, N, N, 8'h00, 8'h00);
      rst = 1'b0;
      #1;
      check_zero(tag);
      #1;
      rst = 1'b1;
   endtask

   // One row per clock cycle: inputs, then the expected outputs in that cycle.
   typedef struct {
      bit          rs;
      bit          ar, aw; logic [7:0] aa, awd;
      bit          br, bw; logic [7:0] ba, bwd;
      bit          eag, ebg, earv, ebrv, ewe, ebusy;
      logic [7:0]  eaddr, ewd, erd;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   typedef struct { bit pend; bit we; logic [7:0] addr; logic [7:0] wd; } req_t;
   typedef struct { int due; int port; logic [7:0] data; } resp_t;

   req_t       rq [2];
   resp_t      resp_q [$];
   logic [7:0] sb_mem [256];
   logic [7:0] model_rd [2];

   initial begin
      vec_t       v;
      int         win, next_ok, last_rd, last_owner;
      logic [7:0] last_addr, last_wd, exp_addr, exp_wd;
      bit         exp_we;
      bit         exp_rv [2];

      //           rs  A:req we addr   wdata   B:req we addr   wdata   agnt bgnt arv brv we busy  addr   wdata  rdata
      vecs[0]  = '{N,  Y, Y, 8'h00, 8'hFF,  N, N, 8'h00, 8'h00,  Y, N, N, N, Y, N,  8'h00, 8'hFF, 8'h00};
      vecs[1]  = '{N,  Y, N, 8'h00, 8'h00,  N, N, 8'h00, 8'h00,  Y, N, N, N, N, N,  8'h00, 8'h00, 8'h00};
      vecs[2]  = '{N,  N, N, 8'h00, 8'h00,  N, N, 8'h00, 8'h00,  N, N, N, N, N, Y,  8'h00, 8'h00, 8'h00};
      vecs[3]  = '{N,  N, N, 8'h00, 8'h00,  N, N, 8'h00, 8'h00,  N, N, Y, N, N, Y,  8'h00, 8'h00, 8'hFF};
      vecs[4]  = '{N,  N, N, 8'h00, 8'h00,  Y, Y, 8'h02, 8'hAA,  N, Y, N, N, Y, N,  8'h02, 8'hAA, 8'h00};
      vecs[5]  = '{N,  N, N, 8'h00, 8'h00,  Y, Y, 8'h03, 8'hF0,  N, Y, N, N, Y, N,  8'h03, 8'hF0, 8'h00};
      vecs[6]  = '{N,  N, N, 8'h00, 8'h00,  Y, N, 8'h02, 8'h00,  N, Y, N, N, N, N,  8'h02, 8'h00, 8'h00};
      vecs[7]  = '{N,  N, N, 8'h00, 8'h00,  Y, N, 8'h03, 8'h00,  N, N, N, N, N, Y,  8'h02, 8'h00, 8'h00};
      vecs[8]  = '{N,  N, N, 8'h00, 8'h00,  Y, N, 8'h03, 8'h00,  N, Y, N, Y, N, Y,  8'h03, 8'h00, 8'hAA};
      vecs[9]  = '{N,  N, N, 8'h00, 8'h00,  N, N, 8'h00, 8'h00,  N, N, N, N, N, Y,  8'h03, 8'h00, 8'h00};
      vecs[10] = '{N,  N, N, 8'h00, 8'h00,  N, N, 8'h00, 8'h00,  N, N, N, Y, N, Y,  8'h03, 8'h00, 8'hF0};
      vecs[11] = '{N,  N, N, 8'h00, 8'h00,  N, N, 8'h00, 8'h00,  N, N, N, N, N, N,  8'h03, 8'h00, 8'h00};
      vecs[12] = '{Y,  Y, N, 8'h02, 8'h00,  Y, N, 8'h03, 8'h00,  Y, N, N, N, N, N,  8'h02, 8'h00, 8'h00};
      vecs[13] = '{N,  N, N, 8'h00, 8'h00,  Y, N, 8'h03, 8'h00,  N, N, N, N, N, Y,  8'h02, 8'h00, 8'h00};
      vecs[14] = '{N,  N, N, 8'h00, 8'h00,  Y, N, 8'h03, 8'h00,  N, Y, Y, N, N, Y,  8'h03, 8'h00, 8'hAA};
      vecs[15] = '{N,  Y, Y, 8'h10, 8'h55,  N, N, 8'h00, 8'h00,  N, N, N, N, N, Y,  8'h03, 8'h00, 8'h00};
      vecs[16] = '{N,  Y, Y, 8'h10, 8'h55,  N, N, 8'h00, 8'h00,  Y, N, N, Y, Y, Y,  8'h10, 8'h55, 8'hF0};
      vecs[17] = '{N,  Y, N, 8'h10, 8'h00,  Y, N, 8'h00, 8'h00,  FIXED, !FIXED, N, N, N, N,
                   FIXED ? 8'h10 : 8'h00, 8'h00, 8'h00};
      vecs[18] = '{N,  !FIXED, N, 8'h10, 8'h00,  FIXED, N, 8'h00, 8'h00,  N, N, N, N, N, Y,
                   FIXED ? 8'h10 : 8'h00, 8'h00, 8'h00};
      vecs[19] = '{N,  !FIXED, N, 8'h10, 8'h00,  FIXED, N, 8'h00, 8'h00,  !FIXED, FIXED, FIXED, !FIXED, N, Y,
                   FIXED ? 8'h00 : 8'h10, 8'h00, FIXED ? 8'h55 : 8'hFF};
      vecs[20] = '{N,  N, N, 8'h00, 8'h00,  N, N, 8'h00, 8'h00,  N, N, N, N, N, Y,
                   FIXED ? 8'h00 : 8'h10, 8'h00, 8'h00};
      vecs[21] = '{N,  N, N, 8'h00, 8'h00,  N, N, 8'h00, 8'h00,  N, N, !FIXED, FIXED, N, Y,
                   FIXED ? 8'h00 : 8'h10, 8'h00, FIXED ? 8'hFF : 8'h55};
      vecs[22] = '{N,  N, N, 8'h00, 8'h00,  N, N, 8'h00, 8'h00,  N, N, N, N, N, N,
                   FIXED ? 8'h00 : 8'h10, 8'h00, 8'h00};

      // Power-on reset.
      drive(N, N, 8'h00, 8'h00, N, N, 8'h00, 8'h00);
      #12;
      check_zero("por");
      @(negedge clk);
      rst = 1'b1;

      // Directed cycle table.
      for (int i = 0; i < NV; i++) begin
         v = vecs[i];
         if (v.rs) do_reset($sformatf("v%0d rst", i));
         @(posedge clk); #1;
         drive(v.ar, v.aw, v.aa, v.awd, v.br, v.bw, v.ba, v.bwd);
         @(negedge clk);
         check($sformatf("v%0d a_gnt", i),    32'(pa.gnt),    32'(v.eag));
         check($sformatf("v%0d b_gnt", i),    32'(pb.gnt),    32'(v.ebg));
         check($sformatf("v%0d a_rvalid", i), 32'(pa.rvalid), 32'(v.earv));
         check($sformatf("v%0d b_rvalid", i), 32'(pb.rvalid), 32'(v.ebrv));
         check($sformatf("v%0d ram_we", i),   32'(ram_we),    32'(v.ewe));
         check($sformatf("v%0d busy", i),     32'(busy),      32'(v.ebusy));
         check($sformatf("v%0d ram_addr", i), 32'(ram_addr),  32'(v.eaddr));
         if (v.ewe)  check($sformatf("v%0d ram_wdata", i), 32'(ram_wdata), 32'(v.ewd));
         if (v.earv) check($sformatf("v%0d a_rdata", i),   32'(pa.rdata),  32'(v.erd));
         if (v.ebrv) check($sformatf("v%0d b_rdata", i),   32'(pb.rdata),  32'(v.erd));
      end

      // Reset asserted while a B read sits in RD_WAIT.
      @(posedge clk); #1;
      drive(N, N, 8'h00, 8'h00, Y, N, 8'h02, 8'h00);
      @(negedge clk);
      check("mid b_gnt", 32'(pb.gnt), 1);
      @(posedge clk); #1;
      drive(N, N, 8'h00, 8'h00, N, N, 8'h00, 8'h00);
      #1;
      check("mid busy pre", 32'(busy), 1);
      rst = 1'b0;
      #1;
      check_zero("mid rst");
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("post%0d b_rvalid", k), 32'(pb.rvalid), 0);
         check($sformatf("post%0d busy", k),     32'(busy),      0);
      end
      @(posedge clk); #1;
      drive(Y, N, 8'h03, 8'h00, N, N, 8'h00, 8'h00);
      @(negedge clk);
      check("post a_gnt", 32'(pa.gnt), 1);
      check("post busy",  32'(busy),   0);
      check("post addr",  32'(ram_addr), 32'h03);
      @(posedge clk); #1;
      drive(N, N, 8'h00, 8'h00, N, N, 8'h00, 8'h00);
      @(negedge clk);
      check("post a_rvalid early", 32'(pa.rvalid), 0);
      @(negedge clk);
      check("post a_rvalid", 32'(pa.rvalid), 1);
      check("post a_rdata",  32'(pa.rdata),  32'hF0);

      // Randomized run against the cycle-level model.
      do_reset("rnd rst");
      next_ok = 0; last_rd = -100; last_owner = 1;
      last_addr = 8'h00; last_wd = 8'h00;
      model_rd[0] = 8'h00; model_rd[1] = 8'h00;
      rq[0].pend = 1'b0; rq[1].pend = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge clk); #1;
         for (int p = 0; p < 2; p++) begin
            if (!rq[p].pend) begin
               if (cyc < 16) begin
                  // Preload addresses 0..15 through port A so every later read is known.
                  if (p == 0) rq[0] = '{1'b1, 1'b1, 8'(cyc), 8'($urandom)};
               end else if ($urandom_range(0, 3) != 0) begin
                  rq[p].pend = 1'b1;
                  rq[p].we   = ($urandom_range(0, 2) == 0);
                  rq[p].addr = 8'($urandom_range(0, 15));
                  rq[p].wd   = 8'($urandom);
               end
            end
         end
         drive(rq[0].pend, rq[0].we, rq[0].addr, rq[0].wd, rq[1].pend, rq[1].we, rq[1].addr, rq[1].wd);
         @(negedge clk);

         // Winner: grants allowed once the previous access's spacing has elapsed.
         win = -1;
         if (cyc >= next_ok) begin
            if (rq[0].pend && rq[1].pend) win = FIXED ? 0 : ((last_owner == 1) ? 0 : 1);
            else if (rq[0].pend)          win = 0;
            else if (rq[1].pend)          win = 1;
         end
         exp_we   = (win >= 0) && rq[win].we;
         exp_addr = (win >= 0) ? rq[win].addr : last_addr;
         exp_wd   = (win >= 0) ? rq[win].wd   : last_wd;
         for (int p = 0; p < 2; p++) begin
            exp_rv[p] = (resp_q.size() > 0) && (resp_q[0].due == cyc) && (resp_q[0].port == p);
            if (exp_rv[p]) begin
               model_rd[p] = resp_q[0].data;
               void'(resp_q.pop_front());
            end
         end

         check($sformatf("r%0d a_gnt", cyc),     32'(pa.gnt),    32'(win == 0));
         check($sformatf("r%0d b_gnt", cyc),     32'(pb.gnt),    32'(win == 1));
         check($sformatf("r%0d ram_we", cyc),    32'(ram_we),    32'(exp_we));
         check($sformatf("r%0d ram_addr", cyc),  32'(ram_addr),  32'(exp_addr));
         check($sformatf("r%0d ram_wdata", cyc), 32'(ram_wdata), 32'(exp_wd));
         check($sformatf("r%0d a_rvalid", cyc),  32'(pa.rvalid), 32'(exp_rv[0]));
         check($sformatf("r%0d b_rvalid", cyc),  32'(pb.rvalid), 32'(exp_rv[1]));
         check($sformatf("r%0d a_rdata", cyc),   32'(pa.rdata),  32'(model_rd[0]));
         check($sformatf("r%0d b_rdata", cyc),   32'(pb.rdata),  32'(model_rd[1]));
         check($sformatf("r%0d busy", cyc),      32'(busy),
               32'(((cyc - last_rd) == 1) || ((cyc - last_rd) == 2)));

         if (win >= 0) begin
            last_owner = win;
            last_addr  = rq[win].addr;
            last_wd    = rq[win].wd;
            if (rq[win].we) begin
               sb_mem[rq[win].addr] = rq[win].wd;
               next_ok = cyc + 1;
            end else begin
               resp_q.push_back('{cyc + 2, win, sb_mem[rq[win].addr]});
               next_ok = cyc + 2;
               last_rd = cyc;
            end
            rq[win].pend = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
